// File: rtl/dc_write_ctrl.sv
// rtl/dc_write_ctrl.sv - D-cache data-store write port: store align/split, 4-beat fill assembly, one write per cycle
module dc_write_ctrl #(
  parameter int C_LINE_W = 128,
  parameter int C_BEATS  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic [3:0]          st_index,
  input  logic [3:0]          st_offset,
  input  logic [1:0]          st_size,
  input  logic [31:0]         st_data,
  input  logic                st_way2_lo,
  input  logic                st_way2_hi,
  input  logic                fill_valid,
  output logic                fill_ready,
  input  logic [31:0]         fill_data,
  input  logic [3:0]          fill_index,
  input  logic                fill_way2,
  output logic                fill_done,
  output logic [3:0]          index,
  output logic [15:0]         dc_wr_mask_way2,
  output logic [15:0]         dc_wr_mask_way1,
  output logic [C_LINE_W-1:0] dc_write_data
);

  localparam logic [2:0] BEATS     = 3'(C_BEATS);
  localparam logic [2:0] LAST_BEAT = 3'(C_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ST_HI, FILL_WR} state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic                fill_full;
  logic [C_LINE_W-1:0] fill_buf;
  logic [3:0]          fill_idx;
  logic                fill_w2;
  logic [3:0]          hi_index;
  logic [15:0]         hi_mask;
  logic [C_LINE_W-1:0] hi_data;
  logic                hi_way2;

  logic [4:0]          n;
  logic [4:0]          pos;
  logic                split;
  logic [15:0]         lo_mask_c;
  logic [15:0]         hi_mask_c;
  logic [C_LINE_W-1:0] lo_data_c;
  logic [C_LINE_W-1:0] hi_data_c;

  assign st_ready   = !rst && (state != ST_HI) && !fill_full;
  assign fill_ready = !rst && (cnt < BEATS);

  // Each store byte lands in lane (offset+b); lanes past 15 spill into the next line.
  always_comb begin
    n         = (st_size == 2'b00) ? 5'd1 : (st_size == 2'b01) ? 5'd2 : 5'd4;
    split     = ({1'b0, st_offset} + n) > 5'd16;
    pos       = '0;
    lo_mask_c = '1;
    hi_mask_c = '1;
    lo_data_c = '0;
    hi_data_c = '0;
    for (int b = 0; b < 4; b++) begin
      pos = {1'b0, st_offset} + 5'(b);
      if (5'(b) < n) begin
        if (!pos[4]) begin
          lo_mask_c[pos[3:0]] = 1'b0;
          lo_data_c[{pos[3:0], 3'b000} +: 8] = st_data[8*b +: 8];
        end else begin
          hi_mask_c[pos[3:0]] = 1'b0;
          hi_data_c[{pos[3:0], 3'b000} +: 8] = st_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      fill_full       <= 1'b0;
      index           <= '0;
      dc_wr_mask_way2 <= '1;
      dc_wr_mask_way1 <= '1;
      dc_write_data   <= '0;
      fill_done       <= 1'b0;
    end else begin
      fill_done <= 1'b0;

      if (fill_valid && fill_ready) begin
        fill_buf[{cnt[1:0], 5'b00000} +: 32] <= fill_data;
        if (cnt == 3'd0) begin
          fill_idx <= fill_index;
          fill_w2  <= fill_way2;
        end
        cnt <= cnt + 3'd1;
        if (cnt == LAST_BEAT) fill_full <= 1'b1;
      end

      // Priority: pending high half, then a full fill line, then a new store.
      if (state == ST_HI) begin
        index           <= hi_index;
        dc_wr_mask_way2 <= hi_way2 ? hi_mask : 16'hFFFF;
        dc_wr_mask_way1 <= hi_way2 ? 16'hFFFF : hi_mask;
        dc_write_data   <= hi_data;
        state           <= IDLE;
      end else if (fill_full) begin
        index           <= fill_idx;
        dc_wr_mask_way2 <= fill_w2 ? 16'h0000 : 16'hFFFF;
        dc_wr_mask_way1 <= fill_w2 ? 16'hFFFF : 16'h0000;
        dc_write_data   <= fill_buf;
        fill_done       <= 1'b1;
        fill_full       <= 1'b0;
        cnt             <= '0;
        state           <= FILL_WR;
      end else if (st_valid && st_ready) begin
        index           <= st_index;
        dc_wr_mask_way2 <= st_way2_lo ? lo_mask_c : 16'hFFFF;
        dc_wr_mask_way1 <= st_way2_lo ? 16'hFFFF : lo_mask_c;
        dc_write_data   <= lo_data_c;
        hi_index        <= st_index + 4'd1;
        hi_mask         <= hi_mask_c;
        hi_data         <= hi_data_c;
        hi_way2         <= st_way2_hi;
        state           <= split ? ST_HI : IDLE;
      end else begin
        dc_wr_mask_way2 <= 16'hFFFF;
        dc_wr_mask_way1 <= 16'hFFFF;
        state           <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dc_write_ctrl.sv
// tb/tb_dc_write_ctrl.sv - directed self-checking bench for dc_write_ctrl
module tb_dc_write_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         st_valid;
  logic         st_ready;
  logic [3:0]   st_index;
  logic [3:0]   st_offset;
  logic [1:0]   st_size;
  logic [31:0]  st_data;
  logic         st_way2_lo;
  logic         st_way2_hi;
  logic         fill_valid;
  logic         fill_ready;
  logic [31:0]  fill_data;
  logic [3:0]   fill_index;
  logic         fill_way2;
  logic         fill_done;
  logic [3:0]   index;
  logic [15:0]  dc_wr_mask_way2;
  logic [15:0]  dc_wr_mask_way1;
  logic [127:0] dc_write_data;

  int n_vec = 0;
  int n_bad = 0;

  dc_write_ctrl dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_index(st_index),
    .st_offset(st_offset), .st_size(st_size), .st_data(st_data),
    .st_way2_lo(st_way2_lo), .st_way2_hi(st_way2_hi),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_data(fill_data),
    .fill_index(fill_index), .fill_way2(fill_way2), .fill_done(fill_done),
    .index(index), .dc_wr_mask_way2(dc_wr_mask_way2),
    .dc_wr_mask_way1(dc_wr_mask_way1), .dc_write_data(dc_write_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic [3:0] ei, input logic [15:0] em2,
                        input logic [15:0] em1, input logic [127:0] ed, input logic efd);
    chk({tag, ".index"}, 128'(index), 128'(ei));
    chk({tag, ".mask2"}, 128'(dc_wr_mask_way2), 128'(em2));
    chk({tag, ".mask1"}, 128'(dc_wr_mask_way1), 128'(em1));
    chk({tag, ".data"}, dc_write_data, ed);
    chk({tag, ".fill_done"}, 128'(fill_done), 128'(efd));
  endtask

  task automatic set_st(input logic [3:0] idx, input logic [3:0] off, input logic [1:0] sz,
                        input logic [31:0] d, input logic lo2, input logic hi2);
    st_valid = 1'b1; st_index = idx; st_offset = off; st_size = sz;
    st_data = d; st_way2_lo = lo2; st_way2_hi = hi2;
  endtask

  task automatic set_beat(input logic [31:0] d, input logic [3:0] idx, input logic w2);
    fill_valid = 1'b1; fill_data = d; fill_index = idx; fill_way2 = w2;
  endtask

  task automatic idle_in();
    st_valid = 1'b0; fill_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    st_index = '0; st_offset = '0; st_size = '0; st_data = '0;
    st_way2_lo = 1'b0; st_way2_hi = 1'b0;
    fill_data = '0; fill_index = '0; fill_way2 = 1'b0;

    tick(); tick();
    chk_wr("reset", 4'd0, 16'hFFFF, 16'hFFFF, 128'h0, 1'b0);
    chk("reset.st_ready", 128'(st_ready), 128'(0));
    chk("reset.fill_ready", 128'(fill_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("run.st_ready", 128'(st_ready), 128'(1));
    chk("run.fill_ready", 128'(fill_ready), 128'(1));

    // Unsplit 4-byte store into way2
    set_st(4'd5, 4'd2, 2'b10, 32'hDDCCBBAA, 1'b1, 1'b0);
    tick(); idle_in();
    chk_wr("unsplit", 4'd5, 16'hFFC3, 16'hFFFF, 128'h0000_0000_0000_0000_0000_DDCC_BBAA_0000, 1'b0);
    tick();
    chk("unsplit.idle2", 128'(dc_wr_mask_way2), 128'(16'hFFFF));
    chk("unsplit.idle1", 128'(dc_wr_mask_way1), 128'(16'hFFFF));

    // Size 11 ending exactly at byte 15 (no split), back-to-back with a 1-byte store
    set_st(4'd4, 4'd12, 2'b11, 32'h87654321, 1'b1, 1'b0);
    tick();
    chk_wr("size11", 4'd4, 16'h0FFF, 16'hFFFF, 128'h8765_4321_0000_0000_0000_0000_0000_0000, 1'b0);
    chk("size11.st_ready", 128'(st_ready), 128'(1));
    set_st(4'd2, 4'd15, 2'b00, 32'h00000077, 1'b0, 1'b1);
    tick(); idle_in();
    chk_wr("byte15", 4'd2, 16'hFFFF, 16'h7FFF, 128'h7700_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    tick();

    // Split store with index wrap 15 -> 0
    set_st(4'd15, 4'd14, 2'b10, 32'h44332211, 1'b0, 1'b1);
    tick(); idle_in();
    chk_wr("split.lo", 4'd15, 16'hFFFF, 16'h3FFF, 128'h2211_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    chk("split.st_ready_lo", 128'(st_ready), 128'(0));
    tick();
    chk_wr("split.hi", 4'd0, 16'hFFFC, 16'hFFFF, 128'h0000_0000_0000_0000_0000_0000_0000_4433, 1'b0);
    chk("split.st_ready_hi", 128'(st_ready), 128'(1));
    tick();
    chk("split.idle2", 128'(dc_wr_mask_way2), 128'(16'hFFFF));

    // Plain fill into way1
    set_beat(32'h03020100, 4'd9, 1'b0); tick();
    set_beat(32'h07060504, 4'd0, 1'b1); tick();
    set_beat(32'h0B0A0908, 4'd0, 1'b1); tick();
    set_beat(32'h0F0E0D0C, 4'd0, 1'b1); tick(); idle_in();
    chk("fill.ready_full", 128'(fill_ready), 128'(0));
    chk("fill.st_ready_full", 128'(st_ready), 128'(0));
    tick();
    chk_wr("fill", 4'd9, 16'hFFFF, 16'h0000, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1);
    chk("fill.ready_after", 128'(fill_ready), 128'(1));
    tick();
    chk_wr("fill.after", 4'd9, 16'hFFFF, 16'hFFFF, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);

    // Collision: 4th beat and a split store at the same edge
    set_beat(32'h11111111, 4'd3, 1'b1); tick();
    set_beat(32'h22222222, 4'd0, 1'b0); tick();
    set_beat(32'h33333333, 4'd0, 1'b0); tick();
    set_beat(32'h44444444, 4'd0, 1'b0);
    set_st(4'd7, 4'd15, 2'b01, 32'h0000BEEF, 1'b1, 1'b0);
    tick(); idle_in();
    chk_wr("coll.lo", 4'd7, 16'h7FFF, 16'hFFFF, 128'hEF00_0000_0000_0000_0000_0000_0000_0000, 1'b0);
    chk("coll.st_ready_lo", 128'(st_ready), 128'(0));
    tick();
    chk_wr("coll.hi", 4'd8, 16'hFFFF, 16'hFFFE, 128'h0000_0000_0000_0000_0000_0000_0000_00BE, 1'b0);
    chk("coll.st_ready_hi", 128'(st_ready), 128'(0));
    tick();
    chk_wr("coll.fill", 4'd3, 16'h0000, 16'hFFFF, 128'h44444444_33333333_22222222_11111111, 1'b1);
    chk("coll.st_ready_after", 128'(st_ready), 128'(1));
    tick();

    // Back-to-back 2-byte stores while beats 0..2 arrive
    for (int i = 0; i < 3; i++) begin
      set_beat(32'hA3A2A1A0 + 32'(i) * 32'h10101010, 4'd12, 1'b1);
      set_st(4'(i + 1), 4'd0, 2'b01, 32'h00005A00 + 32'(i), 1'b0, 1'b0);
      tick();
      chk_wr($sformatf("bb%0d", i), 4'(i + 1), 16'hFFFF, 16'hFFFC, 128'(32'h00005A00 + 32'(i)), 1'b0);
    end
    idle_in();
    set_beat(32'hD3D2D1D0, 4'd0, 1'b0); tick(); idle_in();
    chk("bb.idle_mask1", 128'(dc_wr_mask_way1), 128'(16'hFFFF));
    tick();
    chk_wr("bb.fill", 4'd12, 16'h0000, 16'hFFFF, 128'hD3D2D1D0_C3C2C1C0_B3B2B1B0_A3A2A1A0, 1'b1);
    tick();

    // Reset with two beats collected and a split high half pending
    set_beat(32'h01010101, 4'd6, 1'b0); tick();
    set_beat(32'h02020202, 4'd0, 1'b0);
    set_st(4'd1, 4'd15, 2'b01, 32'h00001234, 1'b0, 1'b1);
    tick(); idle_in();
    chk("rstmid.lo_mask1", 128'(dc_wr_mask_way1), 128'(16'h7FFF));
    rst = 1'b1;
    tick();
    chk_wr("rstmid", 4'd0, 16'hFFFF, 16'hFFFF, 128'h0, 1'b0);
    chk("rstmid.st_ready", 128'(st_ready), 128'(0));
    chk("rstmid.fill_ready", 128'(fill_ready), 128'(0));
    rst = 1'b0;
    tick();
    chk_wr("rstmid.nohi", 4'd0, 16'hFFFF, 16'hFFFF, 128'h0, 1'b0);
    set_beat(32'hE0E0E0E0, 4'd10, 1'b1); tick();
    set_beat(32'hE1E1E1E1, 4'd0, 1'b0); tick();
    set_beat(32'hE2E2E2E2, 4'd0, 1'b0); tick(); idle_in();
    chk("rstmid.ready3", 128'(fill_ready), 128'(1));
    chk("rstmid.no_early", 128'(fill_done), 128'(0));
    tick();
    chk("rstmid.no_early2", 128'(fill_done), 128'(0));
    set_beat(32'hE3E3E3E3, 4'd0, 1'b0); tick(); idle_in();
    chk("rstmid.ready4", 128'(fill_ready), 128'(0));
    tick();
    chk_wr("rstmid.fill", 4'd10, 16'h0000, 16'hFFFF, 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0, 1'b1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dc_write_ctrl.md
# dc_write_ctrl

Write-port controller for the D-cache data store (2 ways × 16 lines × 16 B). It sits between the memory-stage store-commit path, the bus-fill return path and the data store. It arbitrates between them, aligns and splits stores, assembles 4-beat line fills, and drives the store's index, active-low byte write masks and write data. It issues at most one write per cycle, and every write output comes from a flop.

## Interface
- C_LINE_W, 128: line width in bits (16 B); fixed.
- C_BEATS, 4: fill beats per line, 32 b each; fixed.

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- st_valid  in  1  store-commit request valid.
- st_ready  out  1  store accepted on the edge where st_valid && st_ready.
- st_index  in  4  line index of the first byte.
- st_offset  in  4  byte offset of the first byte within the line.
- st_size  in  2  size code: 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 4 B.
- st_data  in  32  store data; byte 0 goes to the lowest address.
- st_way2_lo  in  1  way for the first line: 1 = way2, 0 = way1.
- st_way2_hi  in  1  way for line index+1; used only when the store splits.
- fill_valid  in  1  fill beat valid.
- fill_ready  out  1  beat accepted on the edge where fill_valid && fill_ready.
- fill_data  in  32  beat data; beat n carries line bytes 4n+3..4n.
- fill_index  in  4  line index; sampled with beat 0 only.
- fill_way2  in  1  victim way; sampled with beat 0 only.
- fill_done  out  1  one-cycle pulse, high in the cycle the fill line write is presented.
- index  out  4  data-store line index.
- dc_wr_mask_way2  out  16  active-low byte write enables, way2.
- dc_wr_mask_way1  out  16  active-low byte write enables, way1.
- dc_write_data  out  128  data-store write data.

## Operation
- **Write-port FSM.** States are IDLE, ST_HI and FILL_WR. Each edge takes the first matching action:
  1. ST_HI pending: load the high half of the split store.
  2. fill_full: load the fill line, go to FILL_WR, then clear fill_full and the beat count.
  3. st_valid && st_ready: load the low half of the store. Go to ST_HI if the store splits, otherwise IDLE.
  4. Otherwise: load the idle write (both masks 16'hFFFF; index and data hold).
- **Store ready.** st_ready = !rst && !(state==ST_HI) && !fill_full. A pending fill therefore blocks new stores for exactly one cycle.
- **Store alignment.** n = 1/2/4 for size 00/01/10, and 4 for size 11.
  - Byte b of st_data goes to lane (st_offset+b) mod 16. Lanes not written carry 0.
  - Low mask: clear bits st_offset .. min(st_offset+n-1, 15) in the selected way. The other way stays 16'hFFFF.
- **Split.** The store splits when st_offset+n > 16.
  - High half uses index st_index+1 mod 16, so 15 wraps to 0.
  - High mask clears bits 0 .. st_offset+n-17 in the st_way2_hi way.
  - The rotated data word and the high-half fields are captured at acceptance.
- **Fill assembly** runs independently of the FSM.
  - Beat counter 0..4. fill_ready = !rst && cnt<4.
  - Beat n writes buffer bytes 4n+3..4n. Beat 0 also latches fill_index and fill_way2.
  - cnt reaching 4 sets fill_full.
  - Beats for the next line are accepted from the cycle after the buffer is loaded into the write registers.
- **Fill write.** index = latched fill_index, data = the buffer, mask = 16'h0000 in the victim way and 16'hFFFF in the other. fill_done is high for that cycle.
- **Reset (rst=1 at an edge).**
  - FSM goes to IDLE; cnt = 0; fill_full = 0.
  - Outputs: index = 0, both masks 16'hFFFF, dc_write_data = 0, fill_done = 0.
  - st_ready and fill_ready are 0 while rst is high.
  - A pending ST_HI, a partial fill or a full fill is discarded; nothing is written.

## Timing
- Store accepted at edge k: its write is presented in cycle k..k+1. A split high half follows in cycle k+1..k+2.
- 4th fill beat accepted at edge k: fill_full is set at k. The fill is presented in cycle k+1..k+2 unless ST_HI holds the port, which delays it by exactly one cycle.
- Sustained throughput is one unsplit store per cycle.
- Masks never request a write in both ways in the same cycle. After any write cycle with no new request, the masks return to 16'hFFFF.

## Test plan
- **Unsplit store.** Reset, then st index=5, off=2, size=10, data=32'hDDCCBBAA, way2_lo=1 → next cycle: index=5, way2 mask=16'hFFC3, way1 mask=16'hFFFF, data bytes 2..5 = AA BB CC DD. Following idle cycle: masks 16'hFFFF.
- **Split with wrap.** st index=15, off=14, size=10, data=32'h44332211, lo=way1, hi=way2 → cycle 1: index=15, way1 mask=16'h3FFF, bytes 14/15 = 11/22. Cycle 2: index=0, way2 mask=16'hFFFC, bytes 0/1 = 33/44. st_ready is low during cycle 1.
- **Fill.** Beats 03020100, 07060504, 0B0A0908, 0F0E0D0C with index=9, way2=0 → one cycle after beat 4: index=9, way1 mask=16'h0000, data=128'h0F0E…0100, fill_done=1. Then fill_ready=1 and cnt=0.
- **Collision.** 4th beat and a split store both accepted at edge k → order is store-lo, store-hi, then fill, with fill_done in the third cycle. st_ready is low during the hi cycle and while fill_full is set.
- **Stores during fill collection.** Issue 2-byte stores back-to-back while beats 0–2 arrive → every store is written in consecutive cycles and the fill buffer is intact.
- **Reset mid-operation.** Assert rst with cnt=2 and ST_HI pending → no high-half write, masks 16'hFFFF, and the next fill needs 4 fresh beats.
